// File: rtl/riscv_branch_predictor.sv
// Bimodal branch predictor: 2-bit saturating counters indexed by PC, plus branch resolution.
// Optional statistics counters are built only when RISCV_BRPRED_STATS_EN is defined.
module riscv_branch_predictor #(
  parameter int XLEN    = 64,
  parameter int ENTRIES = 64
) (
  input  logic            i_riscv_brpred_clk,
  input  logic            i_riscv_brpred_rst_n,
  input  logic            i_riscv_brpred_stall,
  input  logic [XLEN-1:0] i_riscv_brpred_fetch_pc,
  output logic            o_riscv_brpred_predict_taken,
  input  logic            i_riscv_brpred_resolve_valid,
  input  logic [XLEN-1:0] i_riscv_brpred_resolve_pc,
  input  logic [3:0]      i_riscv_brpred_cond,
  input  logic [XLEN-1:0] i_riscv_brpred_rs1data,
  input  logic [XLEN-1:0] i_riscv_brpred_rs2data,
  input  logic            i_riscv_brpred_predicted,
  output logic            o_riscv_brpred_valid,
  output logic            o_riscv_brpred_taken,
  output logic            o_riscv_brpred_mispredict,
  output logic [31:0]     o_riscv_brpred_branch_cnt,
  output logic [31:0]     o_riscv_brpred_miss_cnt
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic [1:0]       cnt_q [ENTRIES];
  logic [1:0]       cnt_d;
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] res_idx;
  logic             accept;
  logic             legal;
  logic             result;
  logic             eq, lt, ltu;
  logic             valid_q, valid_d;
  logic             taken_q, taken_d;
  logic             mis_q, mis_d;
  logic             unused_pc_bits;

  assign fetch_idx = i_riscv_brpred_fetch_pc[IDX_W+1:2];
  assign res_idx   = i_riscv_brpred_resolve_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{i_riscv_brpred_fetch_pc[XLEN-1:IDX_W+2], i_riscv_brpred_fetch_pc[1:0],
                            i_riscv_brpred_resolve_pc[XLEN-1:IDX_W+2], i_riscv_brpred_resolve_pc[1:0]};

  // Read-before-write: the prediction always reflects the registered table.
  assign o_riscv_brpred_predict_taken = cnt_q[fetch_idx][1];

  assign accept = i_riscv_brpred_resolve_valid & i_riscv_brpred_cond[3] & ~i_riscv_brpred_stall;
  // funct3 010/011 are not branches: resolve as not-taken and leave the table alone.
  assign legal  = ~(~i_riscv_brpred_cond[2] & i_riscv_brpred_cond[1]);

  assign eq  = (i_riscv_brpred_rs1data == i_riscv_brpred_rs2data);
  assign lt  = ($signed(i_riscv_brpred_rs1data) < $signed(i_riscv_brpred_rs2data));
  assign ltu = (i_riscv_brpred_rs1data < i_riscv_brpred_rs2data);

  always_comb begin
    result = 1'b0;
    case (i_riscv_brpred_cond[2:0])
      3'b000:  result = eq;
      3'b001:  result = ~eq;
      3'b100:  result = lt;
      3'b101:  result = ~lt;
      3'b110:  result = ltu;
      3'b111:  result = ~ltu;
      default: result = 1'b0;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q[res_idx];
    if (result) begin
      if (cnt_q[res_idx] != 2'b11) cnt_d = cnt_q[res_idx] + 2'b01;
    end else begin
      if (cnt_q[res_idx] != 2'b00) cnt_d = cnt_q[res_idx] - 2'b01;
    end
  end

  // valid is a one-cycle pulse (no ready): taken/mispredict are meaningful only while it is high.
  always_comb begin
    valid_d = accept;
    taken_d = accept & result;
    mis_d   = accept & (result ^ i_riscv_brpred_predicted);
  end

  always_ff @(posedge i_riscv_brpred_clk) begin
    if (!i_riscv_brpred_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= 2'b01;
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      mis_q   <= 1'b0;
    end else if (!i_riscv_brpred_stall) begin
      valid_q <= valid_d;
      taken_q <= taken_d;
      mis_q   <= mis_d;
      if (accept && legal) cnt_q[res_idx] <= cnt_d;
    end
  end

  assign o_riscv_brpred_valid      = valid_q;
  assign o_riscv_brpred_taken      = taken_q;
  assign o_riscv_brpred_mispredict = mis_q;

`ifdef RISCV_BRPRED_STATS_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge i_riscv_brpred_clk) begin
    if (!i_riscv_brpred_rst_n) begin
      branch_cnt_q <= 32'd0;
      miss_cnt_q   <= 32'd0;
    end else if (accept) begin
      if (branch_cnt_q != 32'hFFFF_FFFF) branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mis_d && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign o_riscv_brpred_branch_cnt = branch_cnt_q;
  assign o_riscv_brpred_miss_cnt   = miss_cnt_q;
`else
  assign o_riscv_brpred_branch_cnt = 32'd0;
  assign o_riscv_brpred_miss_cnt   = 32'd0;
`endif

endmodule
